melody_sequencer: RTL and testbench



---
 rtl/melody_pkg.sv | 76 +++++++
 rtl/melody_sequencer_beat_timer.sv | 34 +++
 rtl/melody_sequencer.sv | 155 +++++++++++++++
 tb/tb_melody_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types, note codes and the song ROM for the melody sequencer.
package melody_pkg;

    localparam int unsigned NOTE_W  = 3;
    localparam int unsigned BEATS_W = 4;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned TICK_W  = 32;
    localparam int unsigned PROD_W  = TICK_W + BEATS_W;

    localparam logic [NOTE_W-1:0] NOTE_DO  = 3'd0;
    localparam logic [NOTE_W-1:0] NOTE_RE  = 3'd1;
    localparam logic [NOTE_W-1:0] NOTE_MI  = 3'd2;
    localparam logic [NOTE_W-1:0] NOTE_FA  = 3'd3;
    localparam logic [NOTE_W-1:0] NOTE_SO  = 3'd4;
    localparam logic [NOTE_W-1:0] NOTE_LA  = 3'd5;
    localparam logic [NOTE_W-1:0] NOTE_TI  = 3'd6;
    localparam logic [NOTE_W-1:0] NOTE_DOH = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP,
        DONE
    } state_e;

    typedef struct packed {
        logic                rest;
        logic [NOTE_W-1:0]   note;
        logic [BEATS_W-1:0]  beats;
    } song_entry_t;

    function automatic song_entry_t mk_entry(input logic rest, input logic [NOTE_W-1:0] note,
                                             input logic [BEATS_W-1:0] beats);
        song_entry_t e;
        e.rest  = rest;
        e.note  = note;
        e.beats = beats;
        return e;
    endfunction

    // Entries 8..15 hold an ascending scale; they only play if SONG_LEN is raised.
    function automatic song_entry_t song_rom(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    return mk_entry(1'b0, NOTE_DO,  4'd1);
            4'd1:    return mk_entry(1'b0, NOTE_DO,  4'd1);
            4'd2:    return mk_entry(1'b0, NOTE_SO,  4'd1);
            4'd3:    return mk_entry(1'b0, NOTE_SO,  4'd1);
            4'd4:    return mk_entry(1'b0, NOTE_LA,  4'd1);
            4'd5:    return mk_entry(1'b0, NOTE_LA,  4'd1);
            4'd6:    return mk_entry(1'b0, NOTE_SO,  4'd2);
            4'd7:    return mk_entry(1'b1, NOTE_DO,  4'd1);
            4'd8:    return mk_entry(1'b0, NOTE_DO,  4'd1);
            4'd9:    return mk_entry(1'b0, NOTE_RE,  4'd1);
            4'd10:   return mk_entry(1'b0, NOTE_MI,  4'd1);
            4'd11:   return mk_entry(1'b0, NOTE_FA,  4'd1);
            4'd12:   return mk_entry(1'b0, NOTE_SO,  4'd1);
            4'd13:   return mk_entry(1'b0, NOTE_LA,  4'd1);
            4'd14:   return mk_entry(1'b0, NOTE_TI,  4'd1);
            default: return mk_entry(1'b0, NOTE_DOH, 4'd1);
        endcase
    endfunction

    // Timer reload for a PLAY entry: beats*beat_ticks-1, product kept at 36 bits, saturated.
    function automatic logic [TICK_W-1:0] play_len(input song_entry_t e,
                                                   input logic [TICK_W-1:0] beat_ticks);
        logic [BEATS_W-1:0] b;
        logic [PROD_W-1:0]  p;
        b = (e.beats == '0) ? BEATS_W'(1) : e.beats;
        p = PROD_W'(b) * PROD_W'(beat_ticks) - PROD_W'(1);
        if (p[PROD_W-1:TICK_W] != '0) begin
            return '1;
        end
        return p[TICK_W-1:0];
    endfunction

endpackage

// File: rtl/melody_sequencer_beat_timer.sv
// Loadable down-counter with a zero flag; times both note and gap durations.
module beat_timer
    import melody_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [TICK_W-1:0] load_val_i,
    output logic              zero_o
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TICK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/melody_sequencer.sv
// Song ROM player: drives note select and tone enable for the tone selector / audio divider.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter logic [31:0] BEAT_TICKS = 32'd12_500_000,
    parameter logic [31:0] GAP_TICKS  = 32'd1_250_000,
    parameter int unsigned SONG_LEN   = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    output logic [2:0] note_sel,
    output logic       tone_en,
    output logic       busy,
    output logic [3:0] note_idx,
    output logic       done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

    state_e            state_q, state_d;
    logic [NOTE_W-1:0] note_sel_q, note_sel_d;
    logic              tone_en_q, tone_en_d;
    logic              busy_q, busy_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;

    logic              timer_zero_c;
    logic              load_c;
    logic [TICK_W-1:0] load_val_c;
    logic              advance_c;
    logic [IDX_W-1:0]  next_idx_c;
    song_entry_t       first_entry_c;
    song_entry_t       adv_entry_c;

    beat_timer u_timer (
        .clk        (CLOCK_50),
        .rst        (reset),
        .load_i     (load_c),
        .load_val_i (load_val_c),
        .zero_o     (timer_zero_c)
    );

    // Next state and next registered outputs; stop overrides everything at the end.
    always_comb begin
        state_d       = state_q;
        note_sel_d    = note_sel_q;
        tone_en_d     = tone_en_q;
        busy_d        = busy_q;
        idx_d         = idx_q;
        done_d        = 1'b0;
        load_c        = 1'b0;
        load_val_c    = '0;
        advance_c     = 1'b0;
        next_idx_c    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        first_entry_c = song_rom('0);
        adv_entry_c   = song_rom(next_idx_c);

        unique case (state_q)
            IDLE: begin
                tone_en_d = 1'b0;
                busy_d    = 1'b0;
                idx_d     = '0;
                if (start && !stop) begin
                    state_d    = PLAY;
                    note_sel_d = first_entry_c.note;
                    tone_en_d  = ~first_entry_c.rest;
                    busy_d     = 1'b1;
                    load_c     = 1'b1;
                    load_val_c = play_len(first_entry_c, BEAT_TICKS);
                end
            end
            PLAY: begin
                if (timer_zero_c) begin
                    if (GAP_TICKS != 32'd0) begin
                        state_d    = GAP;
                        tone_en_d  = 1'b0;
                        load_c     = 1'b1;
                        load_val_c = GAP_TICKS - 32'd1;
                    end else begin
                        advance_c = 1'b1;
                    end
                end
            end
            GAP: begin
                if (timer_zero_c) begin
                    advance_c = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
                load_c  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Step to the next entry, wrap when looping, otherwise finish.
        if (advance_c) begin
            if ((idx_q != LAST_IDX) || loop_en) begin
                state_d    = PLAY;
                idx_d      = next_idx_c;
                note_sel_d = adv_entry_c.note;
                tone_en_d  = ~adv_entry_c.rest;
                load_c     = 1'b1;
                load_val_c = play_len(adv_entry_c, BEAT_TICKS);
            end else begin
                state_d   = DONE;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                tone_en_d = 1'b0;
                load_c    = 1'b1;
            end
        end

        if (stop) begin
            state_d    = IDLE;
            tone_en_d  = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            idx_d      = '0;
            load_c     = 1'b1;
            load_val_c = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            note_sel_q <= '0;
            tone_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            idx_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_sel_q <= note_sel_d;
            tone_en_q  <= tone_en_d;
            busy_q     <= busy_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
        end
    end

    assign note_sel = note_sel_q;
    assign tone_en  = tone_en_q;
    assign busy     = busy_q;
    assign note_idx = idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_melody_sequencer;

    localparam int BT = 4;

    logic       clk = 1'b0;
    logic       reset, start, start0, stop, loop_en;
    logic [2:0] note_sel, note_sel0;
    logic       tone_en, tone_en0, busy, busy0, done, done0;
    logic [3:0] note_idx, note_idx0;

    melody_sequencer #(.BEAT_TICKS(32'd4), .GAP_TICKS(32'd1), .SONG_LEN(8)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .note_sel (note_sel),
        .tone_en  (tone_en),
        .busy     (busy),
        .note_idx (note_idx),
        .done     (done)
    );

    melody_sequencer #(.BEAT_TICKS(32'd4), .GAP_TICKS(32'd0), .SONG_LEN(8)) dut0 (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start0),
        .stop     (stop),
        .loop_en  (loop_en),
        .note_sel (note_sel0),
        .tone_en  (tone_en0),
        .busy     (busy0),
        .note_idx (note_idx0),
        .done     (done0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         sel;
        bit         nchk;
        logic [2:0] note;
        logic       tone;
        logic       busy;
        logic [3:0] idx;
        logic       done;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt0 = 0;
    int   done_cnt1 = 0;

    // Hand-encoded default song: Do Do So So La La So/2 rest
    int NOTES [8] = '{0, 0, 4, 4, 5, 5, 4, 0};
    int BEATS [8] = '{1, 1, 1, 1, 1, 1, 2, 1};
    int RESTS [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(int off, int gap, bit lp, bit sel, int c, string nm);
        exp_t e;
        int t = 0;
        int k = 0;
        int len;
        e.cyc = c; e.sel = sel; e.nchk = 1'b1; e.name = nm; e.done = 1'b0;
        e.note = 3'd0; e.tone = 1'b0; e.busy = 1'b0; e.idx = 4'd0;
        for (int it = 0; it < 40; it++) begin
            len = BEATS[k] * BT;
            if (off < t + len) begin
                e.note = 3'(NOTES[k]); e.tone = (RESTS[k] == 0); e.busy = 1'b1; e.idx = 4'(k);
                return e;
            end
            t += len;
            if (off < t + gap) begin
                e.note = 3'(NOTES[k]); e.tone = 1'b0; e.busy = 1'b1; e.idx = 4'(k);
                return e;
            end
            t += gap;
            if (k == 7) begin
                if (lp) begin
                    k = 0;
                end else begin
                    e.note = 3'(NOTES[7]); e.busy = 1'b0;
                    e.done = (off == t);
                    e.idx  = (off == t) ? 4'd7 : 4'd0;
                    return e;
                end
            end else begin
                k++;
            end
        end
        return e;
    endfunction

    task automatic push_model(int p, int from, int to, int gap, bit lp, bit sel, string nm);
        for (int o = from; o <= to; o++) q.push_back(model(o, gap, lp, sel, p + o, nm));
    endtask

    task automatic push_idle(int c, bit sel, bit nchk, string nm);
        exp_t e;
        e.cyc = c; e.sel = sel; e.nchk = nchk; e.note = 3'd0; e.tone = 1'b0;
        e.busy = 1'b0; e.idx = 4'd0; e.done = 1'b0; e.name = nm;
        q.push_back(e);
    endtask

    task automatic check(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    exp_t       m_e;
    logic [2:0] a_note;
    logic       a_tone, a_busy, a_done;
    logic [3:0] a_idx;
    bit         bad;

    // Monitor: pops every expectation due this cycle and compares against the selected DUT.
    always @(negedge clk) begin
        if (done)  done_cnt0 = done_cnt0 + 1;
        if (done0) done_cnt1 = done_cnt1 + 1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e    = q.pop_front();
            a_note = m_e.sel ? note_sel0 : note_sel;
            a_tone = m_e.sel ? tone_en0  : tone_en;
            a_busy = m_e.sel ? busy0     : busy;
            a_idx  = m_e.sel ? note_idx0 : note_idx;
            a_done = m_e.sel ? done0     : done;
            bad = (m_e.cyc != cyc) || (m_e.nchk && a_note !== m_e.note) || (a_tone !== m_e.tone)
                  || (a_busy !== m_e.busy) || (a_idx !== m_e.idx) || (a_done !== m_e.done);
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s cyc=%0d(due %0d): got note=%0d tone=%0b busy=%0b idx=%0d done=%0b, expected note=%0d tone=%0b busy=%0b idx=%0d done=%0b",
                         m_e.name, cyc, m_e.cyc, a_note, a_tone, a_busy, a_idx, a_done,
                         m_e.note, m_e.tone, m_e.busy, m_e.idx, m_e.done);
            end
        end
    end

    int p;

    initial begin
        reset = 1'b1; start = 1'b0; start0 = 1'b0; stop = 1'b0; loop_en = 1'b0;
        tick(3);
        reset = 1'b0;
        push_idle(cyc + 1, 1'b0, 1'b1, "reset_state");
        push_idle(cyc + 1, 1'b1, 1'b1, "reset_state0");
        tick(2);

        // Full song, no loop: done 44 cycles after PLAY entry
        p = cyc + 1; start = 1'b1;
        push_model(p, 0, 46, 1, 1'b0, 1'b0, "song");
        tick(1); start = 1'b0;
        tick(46);
        check("done_once", done_cnt0, 1);

        // Looping: wraps to entry 0 after entry 7 gap, then stopped
        loop_en = 1'b1; p = cyc + 1; start = 1'b1;
        push_model(p, 0, 45, 1, 1'b1, 1'b0, "loop");
        tick(1); start = 1'b0;
        tick(45);
        stop = 1'b1;
        push_idle(p + 46, 1'b0, 1'b0, "loop_stop");
        push_idle(p + 47, 1'b0, 1'b0, "loop_stop");
        tick(1); stop = 1'b0; loop_en = 1'b0;
        tick(2);
        check("loop_no_done", done_cnt0, 1);

        // Stop on cycle 2 of entry 3
        p = cyc + 1; start = 1'b1;
        push_model(p, 0, 16, 1, 1'b0, 1'b0, "pre_stop");
        tick(1); start = 1'b0;
        tick(16);
        stop = 1'b1;
        push_idle(p + 17, 1'b0, 1'b0, "stop_idle");
        push_idle(p + 18, 1'b0, 1'b0, "stop_idle");
        tick(1); stop = 1'b0;
        tick(3);
        check("stop_no_done", done_cnt0, 1);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        push_idle(cyc + 1, 1'b0, 1'b0, "start_stop");
        push_idle(cyc + 2, 1'b0, 1'b0, "start_stop");
        push_idle(cyc + 3, 1'b0, 1'b0, "start_stop");
        tick(2); start = 1'b0; stop = 1'b0;
        tick(2);

        // Reset mid entry 4, asynchronous effect, restart only on new start
        p = cyc + 1; start = 1'b1;
        push_model(p, 0, 20, 1, 1'b0, 1'b0, "pre_reset");
        tick(1); start = 1'b0;
        tick(21);
        #1 reset = 1'b1;
        #1;
        check("async_note", int'(note_sel), 0);
        check("async_tone", int'(tone_en), 0);
        check("async_busy", int'(busy), 0);
        check("async_idx", int'(note_idx), 0);
        check("async_done", int'(done), 0);
        for (int i = 21; i <= 26; i++) push_idle(p + i, 1'b0, 1'b1, "after_reset");
        tick(2); reset = 1'b0;
        tick(3);
        p = cyc + 1; start = 1'b1;
        push_model(p, 0, 6, 1, 1'b0, 1'b0, "restart");
        tick(1); start = 1'b0;
        tick(6);
        stop = 1'b1;
        push_idle(p + 7, 1'b0, 1'b0, "restart_stop");
        tick(1); stop = 1'b0;
        tick(1);

        // GAP_TICKS=0: two Do entries back to back, idx 0->1 at cycle 4
        p = cyc + 1; start0 = 1'b1;
        push_model(p, 0, 10, 0, 1'b0, 1'b1, "gap0");
        tick(1); start0 = 1'b0;
        tick(10);
        stop = 1'b1;
        push_idle(p + 11, 1'b1, 1'b0, "gap0_stop");
        tick(1); stop = 1'b0;
        tick(2);
        check("gap0_no_done", done_cnt1, 0);
        check("total_done", done_cnt0, 1);
        check("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
